// File: rtl/mt9v034_lvds_word_aligner.sv
// MT9V034 LVDS word aligner: locates the start/stop framing inside 12-bit SERDES chunks and emits 10-bit pixels.
// Define MT9V034_ALIGN_STATS_EN to add the saturating frame/error/relock statistics counters.
module mt9v034_lvds_word_aligner #(
  parameter int LOCK_COUNT = 16,
  parameter int ERR_LIMIT  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] raw_data,
  input  logic        raw_valid,
  output logic [9:0]  pix_data,
  output logic        pix_valid,
  output logic        locked,
  output logic        frame_err,
  output logic [3:0]  offset
`ifdef MT9V034_ALIGN_STATS_EN
  ,
  input  logic        stat_clr,
  output logic [31:0] stat_frames,
  output logic [15:0] stat_errs,
  output logic [7:0]  stat_relocks
`endif
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [7:0] LOCK_CNT_C = 8'(LOCK_COUNT);
  localparam logic [7:0] ERR_LIM_C  = 8'(ERR_LIMIT);

  state_t      state_r;
  logic [11:0] prev_r;
  logic [7:0]  good_r;
  logic [7:0]  err_r;
  logic [3:0]  offset_r;
  logic [9:0]  pix_data_r;
  logic        pix_valid_r;
  logic        locked_r;
  logic        frame_err_r;

  logic [23:0] window_s;
  logic [11:0] frame_s;
  logic        match_s;
  logic [3:0]  offset_inc_s;
  logic [7:0]  good_inc_s;
  logic [7:0]  err_inc_s;
  logic        enter_lock_s;
  logic        emit_pix_s;
  logic        err_evt_s;
  logic        drop_s;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // A frame is start bit (1) first, stop bit (0) last
  function automatic logic frame_ok(input logic [11:0] f);
    return f[0] & ~f[11];
  endfunction

  assign window_s     = {raw_data, prev_r};
  assign frame_s      = 12'(window_s >> offset_r);
  assign match_s      = frame_ok(frame_s);
  assign offset_inc_s = (offset_r == 4'd11) ? 4'd0 : offset_r + 4'd1;
  assign good_inc_s   = sat_inc8(good_r);
  assign err_inc_s    = sat_inc8(err_r);

  assign enter_lock_s = match_s &&
                        (((state_r == HUNT) && (LOCK_CNT_C <= 8'd1)) ||
                         ((state_r == VERIFY) && (good_inc_s >= LOCK_CNT_C)));
  assign emit_pix_s   = ((state_r == LOCKED) && match_s) || enter_lock_s;
  assign err_evt_s    = (state_r == LOCKED) && !match_s;
  assign drop_s       = err_evt_s && (err_inc_s >= ERR_LIM_C);

  assign pix_data  = pix_data_r;
  assign pix_valid = pix_valid_r;
  assign locked    = locked_r;
  assign frame_err = frame_err_r;
  assign offset    = offset_r;

  // Alignment FSM with registered pixel, lock and framing-error outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= HUNT;
      offset_r    <= 4'd0;
      prev_r      <= 12'd0;
      good_r      <= 8'd0;
      err_r       <= 8'd0;
      pix_data_r  <= 10'd0;
      pix_valid_r <= 1'b0;
      locked_r    <= 1'b0;
      frame_err_r <= 1'b0;
    end else if (raw_valid) begin
      prev_r      <= raw_data;
      pix_valid_r <= emit_pix_s;
      frame_err_r <= err_evt_s;
      if (emit_pix_s) begin
        pix_data_r <= frame_s[10:1];
      end
      case (state_r)
        HUNT: begin
          if (enter_lock_s) begin
            state_r  <= LOCKED;
            locked_r <= 1'b1;
            good_r   <= 8'd1;
            err_r    <= 8'd0;
          end else if (match_s) begin
            state_r <= VERIFY;
            good_r  <= 8'd1;
          end else begin
            offset_r <= offset_inc_s;
          end
        end
        VERIFY: begin
          if (enter_lock_s) begin
            state_r  <= LOCKED;
            locked_r <= 1'b1;
            good_r   <= good_inc_s;
            err_r    <= 8'd0;
          end else if (match_s) begin
            good_r <= good_inc_s;
          end else begin
            state_r  <= HUNT;
            offset_r <= offset_inc_s;
            good_r   <= 8'd0;
          end
        end
        LOCKED: begin
          if (match_s) begin
            err_r <= 8'd0;
          end else if (drop_s) begin
            // Offset is kept so the hunt restarts at the last known-good position
            state_r  <= HUNT;
            locked_r <= 1'b0;
            good_r   <= 8'd0;
            err_r    <= err_inc_s;
          end else begin
            err_r <= err_inc_s;
          end
        end
        default: begin
          state_r  <= HUNT;
          locked_r <= 1'b0;
          good_r   <= 8'd0;
          err_r    <= 8'd0;
        end
      endcase
    end else begin
      pix_valid_r <= 1'b0;
      frame_err_r <= 1'b0;
    end
  end

`ifdef MT9V034_ALIGN_STATS_EN
  logic [31:0] stat_frames_r;
  logic [15:0] stat_errs_r;
  logic [7:0]  stat_relocks_r;

  assign stat_frames  = stat_frames_r;
  assign stat_errs    = stat_errs_r;
  assign stat_relocks = stat_relocks_r;

  // Saturating event counters; a clear overrides a coincident event
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      stat_frames_r  <= 32'd0;
      stat_errs_r    <= 16'd0;
      stat_relocks_r <= 8'd0;
    end else begin
      if (raw_valid && emit_pix_s && (stat_frames_r != 32'hFFFF_FFFF)) begin
        stat_frames_r <= stat_frames_r + 32'd1;
      end
      if (raw_valid && err_evt_s && (stat_errs_r != 16'hFFFF)) begin
        stat_errs_r <= stat_errs_r + 16'd1;
      end
      if (raw_valid && drop_s && (stat_relocks_r != 8'hFF)) begin
        stat_relocks_r <= stat_relocks_r + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mt9v034_lvds_word_aligner.sv
// Directed bench for the MT9V034 word aligner: serial frames are built bit by bit and chunked into 12-bit words.
module tb_mt9v034_lvds_word_aligner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] raw_data = 12'd0;
  logic        raw_valid = 1'b0;
  logic [9:0]  pix_data;
  logic        pix_valid;
  logic        locked;
  logic        frame_err;
  logic [3:0]  offset;

  int total = 0;
  int bad = 0;
  bit bits_q[$];
  int next_val = 0;
  int exp_pix = 0;

  always #5 clk = ~clk;

  mt9v034_lvds_word_aligner #(.LOCK_COUNT(16), .ERR_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .raw_data(raw_data), .raw_valid(raw_valid),
    .pix_data(pix_data), .pix_valid(pix_valid), .locked(locked),
    .frame_err(frame_err), .offset(offset)
  );

  task automatic step(input logic v, input logic [11:0] d);
    raw_valid = v;
    raw_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 12'd0);
    rst = 1'b0;
  endtask

  task automatic start_stream(input int phase);
    bits_q.delete();
    next_val = 0;
    for (int i = 0; i < phase; i++) bits_q.push_back(1'b0);
  endtask

  // Append one serial frame (start, D0..D9, stop) and clock out the next 12-bit chunk
  task automatic send_frame(input logic [9:0] d, input logic stop);
    logic [11:0] chunk;
    bits_q.push_back(1'b1);
    for (int i = 0; i < 10; i++) bits_q.push_back(d[i]);
    bits_q.push_back(stop);
    for (int i = 0; i < 12; i++) chunk[i] = bits_q.pop_front();
    step(1'b1, chunk);
  endtask

  task automatic send_next();
    send_frame(10'(next_val), 1'b0);
    next_val++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(1'b1, 12'hFFF);
    step(1'b0, 12'h000);
    rst = 1'b0;
    total++;
    if ({pix_valid, locked, frame_err} !== 3'b000) begin
      bad++; $display("FAIL reset_flags: got %b want 000", {pix_valid, locked, frame_err});
    end
    total++;
    if (pix_data !== 10'd0) begin
      bad++; $display("FAIL reset_pix: got %h want 000", pix_data);
    end
    total++;
    if (offset !== 4'd0) begin
      bad++; $display("FAIL reset_offset: got %0d want 0", offset);
    end
  endtask

  task automatic test_lock();
    int lock_at = -1;
    int pre_pix = 0;
    logic lk_pv = 1'b0;
    logic [9:0] lk_pd = 10'd0;
    logic [3:0] lk_off = 4'd0;
    do_reset();
    start_stream(5);
    for (int i = 0; i < 60 && lock_at < 0; i++) begin
      send_next();
      if (locked === 1'b1) begin
        lock_at = i; lk_pv = pix_valid; lk_pd = pix_data; lk_off = offset;
      end else if (pix_valid !== 1'b0) begin
        pre_pix++;
      end
    end
    total++;
    if (lock_at != 20) begin bad++; $display("FAIL lock_chunk: got %0d want 20", lock_at); end
    total++;
    if (lk_pv !== 1'b1) begin bad++; $display("FAIL lock_first_valid: got %b want 1", lk_pv); end
    total++;
    if (lk_pd !== 10'd19) begin bad++; $display("FAIL lock_first_pix: got %0d want 19", lk_pd); end
    total++;
    if (lk_off !== 4'd5) begin bad++; $display("FAIL lock_offset: got %0d want 5", lk_off); end
    total++;
    if (pre_pix != 0) begin bad++; $display("FAIL lock_early_pix: got %0d want 0", pre_pix); end
    exp_pix = 19;
    for (int i = 0; i < 20; i++) begin
      send_next();
      exp_pix++;
      total++;
      if (pix_valid !== 1'b1 || pix_data !== 10'(exp_pix) || frame_err !== 1'b0) begin
        bad++; $display("FAIL lock_stream[%0d]: got v=%b d=%0d e=%b want v=1 d=%0d e=0",
                        i, pix_valid, pix_data, frame_err, exp_pix);
      end
    end
  endtask

  task automatic test_err_burst();
    int base = exp_pix;
    for (int j = 0; j < 9; j++) begin
      send_frame(10'(next_val), (j < 3));
      next_val++;
      total++;
      if (j >= 1 && j <= 3) begin
        if (frame_err !== 1'b1 || pix_valid !== 1'b0 || locked !== 1'b1) begin
          bad++; $display("FAIL burst_err[%0d]: got e=%b v=%b l=%b want e=1 v=0 l=1",
                          j, frame_err, pix_valid, locked);
        end
      end else begin
        if (frame_err !== 1'b0 || pix_valid !== 1'b1 || locked !== 1'b1 ||
            pix_data !== 10'(base + 1 + j)) begin
          bad++; $display("FAIL burst_pix[%0d]: got e=%b v=%b l=%b d=%0d want e=0 v=1 l=1 d=%0d",
                          j, frame_err, pix_valid, locked, pix_data, base + 1 + j);
        end
      end
    end
  endtask

  task automatic test_slip();
    int m = next_val;
    int n_err = 0;
    bits_q.push_back(1'b0);
    for (int j = 0; j < 22; j++) begin
      send_next();
      if (frame_err === 1'b1) n_err++;
      if (j == 0) begin
        total++;
        if (pix_valid !== 1'b1 || pix_data !== 10'(m - 1)) begin
          bad++; $display("FAIL slip_last_pix: got v=%b d=%0d want v=1 d=%0d", pix_valid, pix_data, m - 1);
        end
      end else if (j <= 3) begin
        total++;
        if (frame_err !== 1'b1 || locked !== 1'b1) begin
          bad++; $display("FAIL slip_err[%0d]: got e=%b l=%b want e=1 l=1", j, frame_err, locked);
        end
      end else if (j == 4) begin
        total++;
        if (frame_err !== 1'b1 || locked !== 1'b0 || offset !== 4'd5) begin
          bad++; $display("FAIL slip_drop: got e=%b l=%b off=%0d want e=1 l=0 off=5", frame_err, locked, offset);
        end
      end else if (j == 5) begin
        total++;
        if (offset !== 4'd6 || locked !== 1'b0) begin
          bad++; $display("FAIL slip_hunt: got off=%0d l=%b want off=6 l=0", offset, locked);
        end
      end else if (j == 21) begin
        total++;
        if (locked !== 1'b1 || pix_valid !== 1'b1 || pix_data !== 10'(m + 20) || offset !== 4'd6) begin
          bad++; $display("FAIL slip_relock: got l=%b v=%b d=%0d off=%0d want l=1 v=1 d=%0d off=6",
                          locked, pix_valid, pix_data, offset, m + 20);
        end
      end else begin
        total++;
        if (locked !== 1'b0 || pix_valid !== 1'b0) begin
          bad++; $display("FAIL slip_verify[%0d]: got l=%b v=%b want l=0 v=0", j, locked, pix_valid);
        end
      end
    end
    total++;
    if (n_err != 4) begin bad++; $display("FAIL slip_err_count: got %0d want 4", n_err); end
  endtask

  task automatic test_phase_sweep();
    for (int p = 0; p < 12; p++) begin
      int lock_at = -1;
      int n_err = 0;
      int want_at = (p == 0) ? 27 : p + 15;
      logic [9:0] lk_pd = 10'd0;
      logic [3:0] lk_off = 4'd0;
      do_reset();
      start_stream(p);
      for (int i = 0; i < 60 && lock_at < 0; i++) begin
        send_next();
        if (frame_err !== 1'b0) n_err++;
        if (locked === 1'b1) begin
          lock_at = i; lk_pd = pix_data; lk_off = offset;
        end
      end
      total++;
      if (lock_at != want_at || lk_off !== 4'(p) || lk_pd !== 10'(want_at - 1) || n_err != 0) begin
        bad++; $display("FAIL sweep_p%0d: got at=%0d off=%0d d=%0d err=%0d want at=%0d off=%0d d=%0d err=0",
                        p, lock_at, lk_off, lk_pd, n_err, want_at, p, want_at - 1);
      end
    end
  endtask

  task automatic test_const();
    int lock_at = -1;
    int n_err = 0;
    logic [9:0] lk_pd = 10'd0;
    logic [3:0] lk_off = 4'd0;
    do_reset();
    start_stream(7);
    for (int i = 0; i < 60 && lock_at < 0; i++) begin
      if (i < 8) send_next();
      else send_frame(10'h3FF, 1'b0);
      if (frame_err !== 1'b0) n_err++;
      if (locked === 1'b1) begin
        lock_at = i; lk_pd = pix_data; lk_off = offset;
      end
    end
    total++;
    if (lock_at != 22 || lk_off !== 4'd7 || lk_pd !== 10'h3FF || n_err != 0) begin
      bad++; $display("FAIL const_lock: got at=%0d off=%0d d=%h err=%0d want at=22 off=7 d=3ff err=0",
                      lock_at, lk_off, lk_pd, n_err);
    end
    for (int i = 0; i < 5; i++) begin
      send_frame(10'h3FF, 1'b0);
      total++;
      if (pix_valid !== 1'b1 || pix_data !== 10'h3FF) begin
        bad++; $display("FAIL const_pix[%0d]: got v=%b d=%h want v=1 d=3ff", i, pix_valid, pix_data);
      end
    end
  endtask

  task automatic test_reset_mid();
    int lock_at = -1;
    int vcnt = 0;
    logic [9:0] lk_pd = 10'd0;
    do_reset();
    start_stream(3);
    for (int i = 0; i < 40 && !locked; i++) send_next();
    exp_pix = int'(pix_data);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 12'hA5A);
      total++;
      if (pix_valid !== 1'b0 || frame_err !== 1'b0 || locked !== 1'b1) begin
        bad++; $display("FAIL idle[%0d]: got v=%b e=%b l=%b want v=0 e=0 l=1", i, pix_valid, frame_err, locked);
      end
      send_next();
      exp_pix++;
      total++;
      if (pix_valid !== 1'b1 || pix_data !== 10'(exp_pix)) begin
        bad++; $display("FAIL toggle_pix[%0d]: got v=%b d=%0d want v=1 d=%0d", i, pix_valid, pix_data, exp_pix);
      end
    end
    rst = 1'b1;
    step(1'b1, 12'h555);
    rst = 1'b0;
    total++;
    if ({pix_valid, locked, frame_err} !== 3'b000 || pix_data !== 10'd0 || offset !== 4'd0) begin
      bad++; $display("FAIL mid_reset: got v=%b l=%b e=%b d=%0d off=%0d want all 0",
                      pix_valid, locked, frame_err, pix_data, offset);
    end
    start_stream(3);
    for (int i = 0; i < 100 && lock_at < 0; i++) begin
      if (i % 2 == 0) begin
        step(1'b0, 12'hFFF);
      end else begin
        send_next();
        if (locked === 1'b1) begin
          lock_at = vcnt; lk_pd = pix_data;
        end
        vcnt++;
      end
    end
    total++;
    if (lock_at != 18 || lk_pd !== 10'd17 || offset !== 4'd3) begin
      bad++; $display("FAIL mid_relock: got at=%0d d=%0d off=%0d want at=18 d=17 off=3", lock_at, lk_pd, offset);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_err_burst();
    test_slip();
    test_phase_sweep();
    test_const();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mt9v034_lvds_word_aligner.md
Name: mt9v034_lvds_word_aligner

Overview:
- Sits directly downstream of the MT9V034 LVDS serial link, after a 1:12 SERDES that delivers one raw 12-bit chunk per `clk` at an arbitrary bit phase.
- Finds the sensor's 12-bit frame boundary: serial order is start bit (1), D0..D9 LSB first, then stop bit (0).
- Once the boundary is found, the block locks onto that bit offset and outputs aligned 10-bit pixel words with a valid strobe.
- Reports lock status and framing errors to the capture logic.

Parameters:
- LOCK_COUNT, 16: consecutive good frames at the candidate offset required before entering LOCKED (range 1..255).
- ERR_LIMIT, 4: consecutive bad frames in LOCKED before dropping to HUNT (range 1..255).

Ports:
- clk  in  1  pixel/word clock, one raw chunk per cycle max
- rst  in  1  synchronous, active-high reset
- raw_data  in  12  SERDES output; bit 0 is the earliest received serial bit
- raw_valid  in  1  raw_data qualifier
- pix_data  out  10  aligned pixel, D9..D0
- pix_valid  out  1  one-cycle strobe per aligned pixel
- locked  out  1  high in LOCKED state
- frame_err  out  1  one-cycle pulse on framing mismatch while LOCKED
- offset  out  4  current bit offset, 0..11

Behaviour:
- Reset (rst=1 at posedge clk): state=HUNT, offset=0, prev word=0, good/err counters=0. pix_data=0, pix_valid=0, locked=0, frame_err=0.
- Window and frame extraction:
  - On each raw_valid, window w[23:0] = {raw_data, prev}. prev is then updated to raw_data.
  - Frame at offset k is w[k+11:k]. It matches when w[k]==1 and w[k+11]==0.
  - Extracted pixel is w[k+10:k+1].
- Cycles with raw_valid=0: no state change, prev held, pix_valid=0, frame_err=0.
- HUNT:
  - Test the frame at offset.
  - Match: go to VERIFY with good=1.
  - Mismatch: offset advances, wrapping 11 -> 0.
- VERIFY:
  - Match: good increments. When good reaches LOCK_COUNT, go to LOCKED with err=0.
  - Mismatch: go to HUNT with offset+1 (mod 12) and good=0.
  - LOCK_COUNT=1 enters LOCKED directly from HUNT on the first match.
- LOCKED:
  - Match: pix_valid=1, pix_data=extracted pixel, err=0.
  - Mismatch: frame_err=1, pix_valid=0, err increments.
  - When err reaches ERR_LIMIT: go to HUNT, keeping the current offset as the first offset tried.
- Latency:
  - Outputs are registered, one cycle after the raw_valid edge that produced them.
  - locked rises in the same cycle as the first pix_valid.
  - locked falls in the cycle after the ERR_LIMIT-th mismatch.
- No pixels are output outside LOCKED.
- Counters saturate and never wrap.
- rst mid-operation aborts immediately to the reset state.
- offset output always reflects the offset used for the next test.

Optional Feature:
- Macro MT9V034_ALIGN_STATS_EN.
- When defined, the block adds these ports:
  - stat_clr  in  1
  - stat_frames  out  32: count of pix_valid strobes
  - stat_errs  out  16: count of frame_err pulses
  - stat_relocks  out  8: count of LOCKED -> HUNT transitions
- All stats counters saturate, and are cleared by rst or stat_clr. When stat_clr coincides with an event, stat_clr wins.
- When the macro is undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Serial stream with incrementing 10-bit data from 0, chunked at bit phase 5, LOCK_COUNT=16 -> locked rises after the 16th good frame at offset=5; from then on pix_data increments by 1 per pix_valid with no gaps.
- Same stream at each phase 0..11 -> locks at offset equal to that phase; frame_err never pulses.
- Constant data 0x3FF, where D9..D0 can mimic the framing bits, preceded by an incrementing stream -> any false VERIFY at a wrong offset is rejected within 2 frames and the true offset locks; pix_data=0x3FF.
- While locked, corrupt the stop bit of 3 frames then resume, ERR_LIMIT=4 -> 3 frame_err pulses, locked stays 1, pixels resume.
- While locked, shift the stream by 1 bit -> 4 frame_err pulses, locked=0, then relock at the new offset after 16 good frames.
- Assert rst for 1 cycle while LOCKED, with raw_valid toggling 50% -> all outputs return to 0 the next cycle, state is HUNT, offset=0, relock succeeds.
